fpnew_result_buffer: RTL and testbench
======================================

// Module: fpnew_result_buffer
// PURPOSE
// - Output-side result FIFO that sits directly downstream of an FPU opgroup block.
// - Accepts {result, status, ext_bit, tag} from that block and buffers up to Depth entries.
// - Delivers them in order to the writeback/core side over a valid/ready handshake.
// - Keeps sticky accrued-exception flags (fflags) for the CSR.
// PARAMETERS
// - Width    32     result width in bits; matches the opgroup block Width
// - Depth    4      number of buffered entries; legal range 2..16, need not be a power of 2
// - TagType  logic  type of the tag carried alongside each result
// PORTS
// - clk_i            in   1           clock; all state is rising-edge
// - rst_i            in   1           asynchronous reset, active-high
// - flush_i          in   1           synchronous drop of all buffered entries
// - in_valid_i       in   1           upstream result valid
// - in_ready_o       out  1           buffer can accept the result
// - result_i         in   Width       upstream result
// - status_i         in   5           fpnew_pkg::status_t {NV,DZ,OF,UF,NX}
// - extension_bit_i  in   1           upstream extension bit
// - tag_i            in   TagType     upstream tag
// - out_valid_o      out  1           head entry valid
// - out_ready_i      in   1           consumer accepts head
// - result_o         out  Width       head result
// - status_o         out  5           head status
// - extension_bit_o  out  1           head extension bit
// - tag_o            out  TagType     head tag
// - fflags_o         out  5           sticky OR of the status of every accepted result
// - fflags_clr_i     in   1           clear fflags (CSR write)
// - usage_o          out  clog2(Depth+1)  current entry count
// - busy_o           out  1           usage_o != 0
// BEHAVIOUR
// - Reset state:
//   - Pointers, count and fflags_o are 0; out_valid_o=0; busy_o=0; in_ready_o=1.
//   - Data outputs are 0 in reset.
// - Handshake:
//   - push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
//   - in_ready_o = (count < Depth). When full it stays low even if a pop happens in the same cycle; there is no pass-through when full.
//   - out_valid_o = (count != 0). Data outputs show mem[rd_ptr] and hold stable while out_valid_o=1 and out_ready_i=0.
// - Pointers:
//   - wr_ptr and rd_ptr wrap from Depth-1 to 0.
//   - count += push - pop; a simultaneous push and pop leaves count unchanged.
// - Latency: one cycle from push to out_valid_o (entry is written, then visible next cycle).
// - flush_i:
//   - Next cycle, count, wr_ptr and rd_ptr are 0.
//   - A push in the flush cycle is discarded.
//   - out_valid_o is still driven from the pre-flush state during the flush cycle.
//   - fflags_o is NOT cleared by flush_i.
// - fflags:
//   - next = (fflags_clr_i ? 0 : fflags) | (push ? status_i : 0).
//   - A same-cycle push after a clear is therefore retained.
//   - Accumulation happens at acceptance, not at pop.
// - Reset mid-operation: asynchronous return to the reset state; in-flight entries are lost.
// CONFIGURATION
// - FPNEW_RESULT_BYPASS_EN defined:
//   - When count==0 and flush_i=0, out_valid_o=in_valid_i and data outputs pass through combinationally from the inputs.
//   - If out_ready_i=1 in that cycle, the result is consumed without a write (count stays 0): latency 0.
//   - Otherwise it is written normally.
//   - fflags accumulate identically.
// - FPNEW_RESULT_BYPASS_EN undefined: latency is always 1 cycle; no combinational in->out path.
// STRUCTURE
// - Reuse fpnew_pkg::status_t; add the constant fpnew_pkg::RESULT_BUF_MAX_DEPTH=16 to the shared package.
// - Local packed entry struct {result, status, ext_bit, tag}, because it depends on Width/TagType.
// - Storage is an inline register array; no sub-module is warranted.
// - Elaboration assertion: 2 <= Depth <= RESULT_BUF_MAX_DEPTH.
// TESTING
// - Fill: Depth=4, push 4 results 0x3F800000..0x40800000 with out_ready_i=0.
//   -> in_ready_o=0 after the 4th push; usage_o=4; head stays 0x3F800000.
// - Drain order: then out_ready_i=1 for 4 cycles.
//   -> results pop in push order; out_valid_o falls after the 4th pop; busy_o=0.
// - Wrap/concurrency: continuous push+pop for 10 cycles with tags 0..9.
//   -> tags exit 0..9 in order; usage_o constant; no loss across the pointer wrap.
// - fflags: push status NX (0x01), then OF|NX (0x05), with fflags_clr_i plus a DZ (0x08) push in the same cycle.
//   -> fflags_o=0x01, then 0x05, then 0x08.
// - Flush: 3 entries buffered, flush_i together with a push.
//   -> next cycle usage_o=0, out_valid_o=0, fflags_o unchanged; the pushed value never appears.
// - Reset/bypass: assert rst_i asynchronously mid-drain.
//   -> all outputs at reset values before the next edge.
//   -> with FPNEW_RESULT_BYPASS_EN defined and the buffer empty, a push with out_ready_i=1 appears on result_o the same cycle and usage_o stays 0.

Source files
------------

// File: rtl/fpnew_pkg.sv
// Shared FPnew definitions: IEEE exception status flags and common sizing limits.
package fpnew_pkg;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    localparam int unsigned RESULT_BUF_MAX_DEPTH = 16;

endpackage

// File: rtl/fpnew_result_buffer.sv
// In-order result FIFO behind an FPU opgroup block, with sticky accrued-exception flags.
// Define FPNEW_RESULT_BYPASS_EN for a zero-latency combinational path when the buffer is empty.
module fpnew_result_buffer
    import fpnew_pkg::*;
#(
    parameter int unsigned Width   = 32,
    parameter int unsigned Depth   = 4,
    parameter type         TagType = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [Width-1:0]           result_i,
    input  status_t                    status_i,
    input  logic                       extension_bit_i,
    input  TagType                     tag_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [Width-1:0]           result_o,
    output status_t                    status_o,
    output logic                       extension_bit_o,
    output TagType                     tag_o,
    output status_t                    fflags_o,
    input  logic                       fflags_clr_i,
    output logic [$clog2(Depth+1)-1:0] usage_o,
    output logic                       busy_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    if (Depth < 2 || Depth > RESULT_BUF_MAX_DEPTH) begin : g_depth_check
        $error("fpnew_result_buffer: Depth must be within 2..RESULT_BUF_MAX_DEPTH");
    end

    typedef struct packed {
        logic [Width-1:0] result;
        status_t          status;
        logic             ext_bit;
        TagType           tag;
    } entry_t;

    entry_t          mem [Depth];
    logic [PtrW-1:0] wr_ptr, rd_ptr;
    logic [CntW-1:0] count;
    status_t         fflags_q;

    entry_t in_entry, head;
    logic   bypass, push, pop, mem_pop, write, accept;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign in_entry = {result_i, status_i, extension_bit_i, tag_i};

`ifdef FPNEW_RESULT_BYPASS_EN
    // Reset is included so data outputs read 0 while reset is held.
    assign bypass = (count == '0) && !flush_i && !rst_i;
`else
    assign bypass = 1'b0;
`endif

    // Full blocks acceptance outright; a same-cycle pop does not free a slot early.
    assign in_ready_o  = (count != CntW'(Depth));
    assign push        = in_valid_i && in_ready_o;
    assign out_valid_o = bypass ? in_valid_i : (count != '0);
    assign pop         = out_valid_o && out_ready_i;
    assign head        = bypass ? in_entry : mem[rd_ptr];

    assign mem_pop = pop && !bypass;
    assign accept  = push && !flush_i;
    assign write   = accept && !(bypass && out_ready_i);

    assign result_o        = head.result;
    assign status_o        = head.status;
    assign extension_bit_o = head.ext_bit;
    assign tag_o           = head.tag;
    assign fflags_o        = fflags_q;
    assign usage_o         = count;
    assign busy_o          = (count != '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fflags_q <= '0;
            // NOTE: the storage is reset because the head entry drives the data outputs directly.
            for (int i = 0; i < int'(Depth); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (write) begin
                    mem[wr_ptr] <= in_entry;
                    wr_ptr      <= ptr_inc(wr_ptr);
                end
                if (mem_pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                count <= count + CntW'(write) - CntW'(mem_pop);
            end
            // Flags accrue at acceptance; a clear and a same-cycle accepted status combine.
            fflags_q <= (fflags_clr_i ? '0 : fflags_q) | (accept ? status_i : '0);
        end
    end

endmodule

// File: tb/tb_fpnew_result_buffer.sv
// Self-checking bench for fpnew_result_buffer: vector table plus scoreboard-backed corner sequences.
module tb_fpnew_result_buffer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  status;
        logic        ext;
        logic [3:0]  tag;
    } exp_t;

    typedef struct {
        logic        v;
        logic [31:0] res;
        logic [4:0]  st;
        logic [3:0]  tag;
        logic        rdy;
        logic        clr;
        logic [2:0]  exp_usage;
        logic [4:0]  exp_fflags;
    } vec_t;

    logic        clk, rst, flush, in_valid, in_ready, ext_in, out_valid, out_ready;
    logic [31:0] result_in, result_out;
    logic [4:0]  status_in, status_out, fflags;
    logic        ext_out, fflags_clr, busy;
    logic [3:0]  tag_in, tag_out;
    logic [2:0]  usage;

    int   n_cmp = 0;
    int   n_mis = 0;
    exp_t sb[$];
    logic [4:0] model_fflags = '0;
    vec_t vecs[16];

    fpnew_result_buffer #(
        .Width  (32),
        .Depth  (DEPTH),
        .TagType(logic [3:0])
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .result_i       (result_in),
        .status_i       (status_in),
        .extension_bit_i(ext_in),
        .tag_i          (tag_in),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .result_o       (result_out),
        .status_o       (status_out),
        .extension_bit_o(ext_out),
        .tag_o          (tag_out),
        .fflags_o       (fflags),
        .fflags_clr_i   (fflags_clr),
        .usage_o        (usage),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive at posedge+1, compare at negedge against the queue model, advance.
    task automatic step(input logic v, input logic [31:0] res, input logic [4:0] st, input logic ext,
                        input logic [3:0] tag, input logic rdy, input logic fl, input logic clr);
        exp_t e;
        logic bypass, exp_valid, accept;
        int   size;
        in_valid   = v;
        result_in  = res;
        status_in  = st;
        ext_in     = ext;
        tag_in     = tag;
        out_ready  = rdy;
        flush      = fl;
        fflags_clr = clr;
        @(negedge clk);
        e      = '{result: res, status: st, ext: ext, tag: tag};
        size   = sb.size();
        bypass = 1'b0;
`ifdef FPNEW_RESULT_BYPASS_EN
        bypass = (size == 0) && !fl;
`endif
        exp_valid = bypass ? v : (size != 0);
        check("in_ready", 64'(in_ready), 64'(size < DEPTH));
        check("usage", 64'(usage), 64'(size));
        check("busy", 64'(busy), 64'(size != 0));
        check("fflags", 64'(fflags), 64'(model_fflags));
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        if (exp_valid) begin
            check("head", 64'({result_out, status_out, ext_out, tag_out}), 64'(bypass ? e : sb[0]));
        end
        accept       = v && (size < DEPTH) && !fl;
        model_fflags = (clr ? 5'h00 : model_fflags) | (accept ? st : 5'h00);
        if (fl) begin
            sb.delete();
        end else if (bypass) begin
            if (accept && !rdy) sb.push_back(e);
        end else begin
            if (exp_valid && rdy) void'(sb.pop_front());
            if (accept) sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0, 5'h00, 1'b0, 4'h0, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        //            v     res           st     tag   rdy   clr   usage fflags
        vecs[0]  = '{1'b1, 32'h3F800000, 5'h00, 4'd0, 1'b0, 1'b0, 3'd1, 5'h00};
        vecs[1]  = '{1'b1, 32'h40000000, 5'h00, 4'd1, 1'b0, 1'b0, 3'd2, 5'h00};
        vecs[2]  = '{1'b1, 32'h40400000, 5'h00, 4'd2, 1'b0, 1'b0, 3'd3, 5'h00};
        vecs[3]  = '{1'b1, 32'h40800000, 5'h00, 4'd3, 1'b0, 1'b0, 3'd4, 5'h00};
        vecs[4]  = '{1'b1, 32'h41000000, 5'h10, 4'd4, 1'b0, 1'b0, 3'd4, 5'h00};
        vecs[5]  = '{1'b1, 32'h41000000, 5'h10, 4'd4, 1'b1, 1'b0, 3'd3, 5'h00};
        vecs[6]  = '{1'b0, 32'h00000000, 5'h00, 4'd0, 1'b1, 1'b0, 3'd2, 5'h00};
        vecs[7]  = '{1'b0, 32'h00000000, 5'h00, 4'd0, 1'b1, 1'b0, 3'd1, 5'h00};
        vecs[8]  = '{1'b0, 32'h00000000, 5'h00, 4'd0, 1'b1, 1'b0, 3'd0, 5'h00};
        vecs[9]  = '{1'b0, 32'h00000000, 5'h00, 4'd0, 1'b1, 1'b0, 3'd0, 5'h00};
        vecs[10] = '{1'b1, 32'h3F000000, 5'h01, 4'd5, 1'b0, 1'b0, 3'd1, 5'h01};
        vecs[11] = '{1'b1, 32'h3E800000, 5'h05, 4'd6, 1'b0, 1'b0, 3'd2, 5'h05};
        vecs[12] = '{1'b1, 32'h3E000000, 5'h08, 4'd7, 1'b0, 1'b1, 3'd3, 5'h08};
        vecs[13] = '{1'b0, 32'h00000000, 5'h00, 4'd0, 1'b1, 1'b0, 3'd2, 5'h08};
        vecs[14] = '{1'b0, 32'h00000000, 5'h00, 4'd0, 1'b1, 1'b0, 3'd1, 5'h08};
        vecs[15] = '{1'b0, 32'h00000000, 5'h00, 4'd0, 1'b1, 1'b0, 3'd0, 5'h08};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; fflags_clr = 1'b0;
        result_in = '0; status_in = '0; ext_in = 1'b0; tag_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_usage", 64'(usage), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_fflags", 64'(fflags), 64'(0));
        check("rst_result", 64'(result_out), 64'(0));
        rst = 1'b0;

        // Fill, full-with-pop refusal, ordered drain, and fflags accrual/clear.
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].v, vecs[i].res, vecs[i].st, vecs[i].tag[0], vecs[i].tag,
                 vecs[i].rdy, 1'b0, vecs[i].clr);
            check($sformatf("vec%0d_usage", i), 64'(usage), 64'(vecs[i].exp_usage));
            check($sformatf("vec%0d_fflags", i), 64'(fflags), 64'(vecs[i].exp_fflags));
        end

        // Continuous push+pop across the pointer wrap with a steady occupancy of 2.
        step(1'b1, 32'h50000000, 5'h00, 1'b0, 4'd14, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h50000001, 5'h00, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h40000000 + 32'(i), 5'h00, i[0], 4'(i), 1'b1, 1'b0, 1'b0);
            check($sformatf("wrap%0d_usage", i), 64'(usage), 64'(2));
        end
        idle(1'b1);
        idle(1'b1);
        check("wrap_drained", 64'(usage), 64'(0));

        // Flush with a simultaneous push: buffer empties, flags persist, pushed value is dropped.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h60000000 + 32'(i), 5'h00, 1'b0, 4'(i), 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 32'hDEADBEEF, 5'h08, 1'b1, 4'd9, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        check("flush_usage", 64'(usage), 64'(0));
        check("flush_out_valid", 64'(out_valid), 64'(0));
        check("flush_fflags", 64'(fflags), 64'(5'h08));
        step(1'b1, 32'h12345678, 5'h00, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
        idle(1'b1);

        // Asynchronous reset in the middle of a drain.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h70000000 + 32'(i), 5'h02, 1'b1, 4'(i + 8), 1'b0, 1'b0, 1'b0);
        end
        idle(1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'(0));
        check("arst_in_ready", 64'(in_ready), 64'(1));
        check("arst_usage", 64'(usage), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_fflags", 64'(fflags), 64'(0));
        check("arst_data", 64'({result_out, status_out, ext_out, tag_out}), 64'(0));
        sb.delete();
        model_fflags = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Push into an empty buffer with the consumer ready: latency 0 with bypass, else 1.
        step(1'b1, 32'h3FC00000, 5'h01, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0);
`ifdef FPNEW_RESULT_BYPASS_EN
        check("lat_usage", 64'(usage), 64'(0));
`else
        check("lat_usage", 64'(usage), 64'(1));
`endif
        idle(1'b1);
        check("lat_done_usage", 64'(usage), 64'(0));
        check("lat_fflags", 64'(fflags), 64'(5'h01));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
